// File: rtl/sdram_avmm_responder.sv
// Avalon-MM slave modelling the SDRAM controller s1 port on on-chip memory: power-up busy,
// periodic refresh stalls, fixed-latency pipelined reads and outstanding-read back-pressure.
module sdram_avmm_responder #(
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned READ_LAT       = 3,
    parameter int unsigned MAX_PEND       = 2,
    parameter int unsigned INIT_CYCLES    = 8,
    parameter int unsigned REFRESH_PERIOD = 64,
    parameter int unsigned REFRESH_CYCLES = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [22:0] s1_address,
    input  logic [3:0]  s1_byteenable_n,
    input  logic        s1_chipselect,
    input  logic        s1_read_n,
    input  logic        s1_write_n,
    input  logic [31:0] s1_writedata,
    output logic [31:0] s1_readdata,
    output logic        s1_readdatavalid,
    output logic        s1_waitrequest,
    output logic        o_protocol_err
);

    localparam int unsigned CntMaxA = (INIT_CYCLES > REFRESH_CYCLES) ? INIT_CYCLES
                                                                     : REFRESH_CYCLES;
    localparam int unsigned CntMax  = (CntMaxA > REFRESH_PERIOD) ? CntMaxA : REFRESH_PERIOD;
    localparam int unsigned CntW    = $clog2(CntMax + 1);
    localparam int unsigned PendW   = $clog2(MAX_PEND + 1);

    localparam logic [CntW-1:0]  InitLast = CntW'(INIT_CYCLES - 1);
    localparam logic [CntW-1:0]  RunLast  = CntW'((REFRESH_PERIOD == 0) ? 0 : REFRESH_PERIOD - 1);
    localparam logic [CntW-1:0]  RefLast  = CntW'(REFRESH_CYCLES - 1);
    localparam logic [PendW-1:0] PendMax  = PendW'(MAX_PEND);

    typedef enum logic [1:0] {StInit, StRun, StRefresh} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [PendW-1:0]    pend_q, pend_d;
    logic [READ_LAT-1:0] vld_q, vld_d;
    logic [31:0]         dat_q [READ_LAT];
    logic [31:0]         mem_q [2**ADDR_W];
    logic                rdv_q;
    logic [31:0]         rdata_q;
    logic                err_q;
    logic                wait_int;

    logic [ADDR_W-1:0] addr;
    logic              req_rd, req_wr, rd_acc, wr_acc;
    logic              unused_addr;

    assign addr        = s1_address[ADDR_W-1:0];
    assign unused_addr = ^s1_address[22:ADDR_W];
    assign req_rd      = s1_chipselect & ~s1_read_n;
    assign req_wr      = s1_chipselect & ~s1_write_n;
    assign wr_acc      = req_wr & ~wait_int;
    // A simultaneous read+write is an error and is executed as the write alone.
    assign rd_acc      = req_rd & ~req_wr & ~wait_int;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StInit;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        unique case (state_q)
            StInit: begin
                if (cnt_q == InitLast) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                if (REFRESH_PERIOD == 0) begin
                    cnt_d = '0;
                end else if (cnt_q == RunLast) begin
                    state_d = StRefresh;
                    cnt_d   = '0;
                end
            end
            StRefresh: begin
                if (cnt_q == RefLast) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StInit;
                cnt_d   = '0;
            end
        endcase
    end

    // Conservative: a return in the same cycle does not release a full pipeline.
    always_comb begin
        wait_int = (state_q != StRun) || (pend_q == PendMax);
    end

    always_comb begin
        pend_d = pend_q;
        if (rd_acc && !rdv_q) begin
            pend_d = pend_q + 1'b1;
        end else if (!rd_acc && rdv_q) begin
            pend_d = pend_q - 1'b1;
        end
        vld_d[0] = rd_acc;
        for (int k = 1; k < READ_LAT; k++) begin
            vld_d[k] = vld_q[k-1];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend_q  <= '0;
            vld_q   <= '0;
            rdv_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            pend_q <= pend_d;
            vld_q  <= vld_d;
            rdv_q  <= vld_q[READ_LAT-1];
            if (vld_q[READ_LAT-1]) begin
                rdata_q <= dat_q[READ_LAT-1];
            end
            err_q <= err_q | (req_rd & req_wr);
        end
    end

    // Memory and read-data pipeline carry no reset; only the valid bits qualify the data.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_acc && !s1_byteenable_n[i]) begin
                mem_q[addr][8*i +: 8] <= s1_writedata[8*i +: 8];
            end
        end
        dat_q[0] <= mem_q[addr];
        for (int k = 1; k < READ_LAT; k++) begin
            dat_q[k] <= dat_q[k-1];
        end
    end

    assign s1_waitrequest   = wait_int;
    assign s1_readdatavalid = rdv_q;
    assign s1_readdata      = rdata_q;
    assign o_protocol_err   = err_q;

endmodule

// File: tb/tb_sdram_avmm_responder.sv
// Directed bench for sdram_avmm_responder: a cycle model predicts waitrequest, read returns
// (queued when a read is accepted, popped on its due cycle) and the sticky error flag.
module tb_sdram_avmm_responder;

    localparam int INIT = 8;
    localparam int LAT  = 3;
    localparam int MAXP = 2;
    localparam int PER  = 64;
    localparam int RCYC = 4;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [22:0] s1_address;
    logic [3:0]  s1_byteenable_n;
    logic        s1_chipselect;
    logic        s1_read_n;
    logic        s1_write_n;
    logic [31:0] s1_writedata;
    logic [31:0] s1_readdata;
    logic        s1_readdatavalid;
    logic        s1_waitrequest;
    logic        o_protocol_err;

    sdram_avmm_responder #(
        .ADDR_W        (10),
        .READ_LAT      (LAT),
        .MAX_PEND      (MAXP),
        .INIT_CYCLES   (INIT),
        .REFRESH_PERIOD(PER),
        .REFRESH_CYCLES(RCYC)
    ) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .s1_address      (s1_address),
        .s1_byteenable_n (s1_byteenable_n),
        .s1_chipselect   (s1_chipselect),
        .s1_read_n       (s1_read_n),
        .s1_write_n      (s1_write_n),
        .s1_writedata    (s1_writedata),
        .s1_readdata     (s1_readdata),
        .s1_readdatavalid(s1_readdatavalid),
        .s1_waitrequest  (s1_waitrequest),
        .o_protocol_err  (o_protocol_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int          due;
        logic [31:0] data;
        bit          known;
    } rd_t;

    rd_t         sb_q[$];
    logic [31:0] mem_m [1024];
    bit          known_m [1024];
    int          t;
    int          checks = 0;
    int          errors = 0;
    int          rdv_seen = 0;
    bit          err_exp = 1'b0;
    logic [31:0] rdata_exp = '0;
    bit          rdata_known = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Edges since reset release.
    always @(posedge i_clk) begin
        if (!i_rst_n) t <= 0;
        else t <= t + 1;
    end

    always @(negedge i_clk) begin
        bit   exp_v, busy, exp_w, rq_rd, rq_wr;
        int   a;
        rq_rd = s1_chipselect && !s1_read_n;
        rq_wr = s1_chipselect && !s1_write_n;
        a     = int'(s1_address[9:0]);
        if (!i_rst_n) begin
            sb_q.delete();
            err_exp     = 1'b0;
            rdata_exp   = '0;
            rdata_known = 1'b1;
            check("rst_wait", {31'd0, s1_waitrequest}, 32'd1);
            check("rst_rdv", {31'd0, s1_readdatavalid}, 32'd0);
            check("rst_rdata", s1_readdata, 32'd0);
            check("rst_err", {31'd0, o_protocol_err}, 32'd0);
        end else begin
            while (sb_q.size() > 0 && sb_q[0].due < t) void'(sb_q.pop_front());
            exp_v = (sb_q.size() > 0 && sb_q[0].due == t);
            check("rdv", {31'd0, s1_readdatavalid}, {31'd0, exp_v});
            if (s1_readdatavalid) rdv_seen++;
            if (exp_v) begin
                rdata_exp   = sb_q[0].data;
                rdata_known = sb_q[0].known;
            end
            if (rdata_known) check("rdata", s1_readdata, rdata_exp);
            check("err", {31'd0, o_protocol_err}, {31'd0, err_exp});
            busy  = (t < INIT) || (((t - INIT) % (PER + RCYC)) >= PER);
            exp_w = busy || (sb_q.size() == MAXP);
            check("wait", {31'd0, s1_waitrequest}, {31'd0, exp_w});
            if (rq_rd && rq_wr) err_exp = 1'b1;
            if (!exp_w) begin
                if (rq_wr) begin
                    for (int i = 0; i < 4; i++) begin
                        if (!s1_byteenable_n[i]) mem_m[a][8*i +: 8] = s1_writedata[8*i +: 8];
                    end
                    known_m[a] = known_m[a] || (s1_byteenable_n == 4'h0);
                end else if (rq_rd) begin
                    sb_q.push_back('{due: t + 1 + LAT, data: mem_m[a], known: known_m[a]});
                end
            end
        end
    end

    task automatic idle();
        s1_chipselect   = 1'b0;
        s1_read_n       = 1'b1;
        s1_write_n      = 1'b1;
        s1_byteenable_n = 4'hF;
    endtask

    // Called at posedge+1 with a request driven; returns at posedge+1 after its accept edge.
    task automatic wait_accept();
        int n = 0;
        @(negedge i_clk);
        while (s1_waitrequest && n < 300) begin
            n++;
            @(negedge i_clk);
        end
        check("accept_timeout", n, (n < 300) ? n : 300 - 1);
        @(posedge i_clk);
        #1;
    endtask

    task automatic rd(input logic [22:0] a);
        s1_chipselect = 1'b1;
        s1_read_n     = 1'b0;
        s1_write_n    = 1'b1;
        s1_address    = a;
        wait_accept();
    endtask

    task automatic wr(input logic [22:0] a, input logic [31:0] d, input logic [3:0] be_n);
        s1_chipselect   = 1'b1;
        s1_read_n       = 1'b1;
        s1_write_n      = 1'b0;
        s1_address      = a;
        s1_writedata    = d;
        s1_byteenable_n = be_n;
        wait_accept();
    endtask

    task automatic drain();
        repeat (6) @(posedge i_clk);
        #1;
    endtask

    task automatic run_until(input int target);
        int n = 0;
        while (t < target && n < 1000) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        check("run_until_edge", t, target);
    endtask

    initial begin
        int t0, t1, t2, t3, seen0, busy_cnt;
        for (int i = 0; i < 1024; i++) known_m[i] = 1'b0;
        idle();
        s1_address   = '0;
        s1_writedata = '0;
        i_rst_n      = 1'b1;
        #2 i_rst_n = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;

        // Reset/init: read of address 5 held from release, accepted on edge INIT+1.
        seen0         = rdv_seen;
        s1_chipselect = 1'b1;
        s1_read_n     = 1'b0;
        s1_address    = 23'd5;
        i_rst_n       = 1'b1;
        wait_accept();
        check("init_accept_edge", t, INIT + 1);
        idle();
        drain();
        check("init_rdv_count", rdv_seen - seen0, 1);

        // Byte-enable merge.
        wr(23'h10, 32'hAABBCCDD, 4'b0000);
        wr(23'h10, 32'h11223344, 4'b1010);
        idle();
        @(posedge i_clk);
        #1;
        rd(23'h10);
        idle();
        drain();
        check("be_merge", s1_readdata, 32'hAA22CC44);

        // Back-to-back reads with back-pressure at two outstanding.
        for (int i = 0; i < 4; i++) wr(23'(i), 32'hC0DE0000 + 32'(i * 17), 4'h0);
        seen0 = rdv_seen;
        rd(23'd0); t0 = t;
        rd(23'd1); t1 = t;
        rd(23'd2); t2 = t;
        rd(23'd3); t3 = t;
        idle();
        drain();
        check("b2b_second", t1 - t0, 1);
        check("b2b_third", t2 - t0, 5);
        check("b2b_fourth", t3 - t0, 6);
        check("b2b_rdv_count", rdv_seen - seen0, 4);
        check("b2b_last_data", s1_readdata, 32'hC0DE0000 + 32'd51);

        // Refresh: read in the last RUN cycle returns during REFRESH; 4 busy per 68.
        wr(23'h20, 32'h5A5AA5A5, 4'h0);
        idle();
        run_until(INIT + PER - 1);
        seen0 = rdv_seen;
        rd(23'h20);
        check("refresh_accept_edge", t, INIT + PER);
        idle();
        run_until(INIT + PER + RCYC);
        check("refresh_rdv_count", rdv_seen - seen0, 1);
        check("refresh_rdata", s1_readdata, 32'h5A5AA5A5);
        busy_cnt = 0;
        repeat (PER + RCYC) begin
            @(negedge i_clk);
            if (s1_waitrequest) busy_cnt++;
        end
        check("refresh_busy_cycles", busy_cnt, RCYC);
        @(posedge i_clk);
        #1;

        // Protocol error: write-only execution, sticky flag, no read strobe.
        seen0           = rdv_seen;
        s1_chipselect   = 1'b1;
        s1_read_n       = 1'b0;
        s1_write_n      = 1'b0;
        s1_address      = 23'd7;
        s1_writedata    = 32'h12345678;
        s1_byteenable_n = 4'h0;
        wait_accept();
        idle();
        drain();
        check("proto_err_set", {31'd0, o_protocol_err}, 32'd1);
        check("proto_no_rdv", rdv_seen - seen0, 0);
        rd(23'd7);
        idle();
        drain();
        check("proto_write_data", s1_readdata, 32'h12345678);
        check("proto_err_sticky", {31'd0, o_protocol_err}, 32'd1);

        // Reset mid-read flushes the return; memory survives.
        seen0 = rdv_seen;
        rd(23'h10);
        idle();
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        repeat (12) @(posedge i_clk);
        #1;
        check("flush_no_rdv", rdv_seen - seen0, 0);
        check("err_cleared", {31'd0, o_protocol_err}, 32'd0);
        rd(23'h10);
        idle();
        drain();
        check("mem_kept_10", s1_readdata, 32'hAA22CC44);
        rd(23'd7);
        idle();
        drain();
        check("mem_kept_7", s1_readdata, 32'h12345678);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
